// File: rtl/fmc_adc_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fmc_adc_pattern_gen: ADC sample pass-through or per-channel test pattern.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fmc_adc_pattern_gen #(
    parameter int g_NB_CHANNELS = 4,
    parameter int g_DATA_WIDTH  = 16,
    parameter int g_HOLD_WIDTH  = 16
) (
    input  logic                                  sys_clk_i,
    input  logic                                  sys_rst_i,
    input  logic                                  en_i,
    input  logic [1:0]                            mode_i,
    input  logic [g_DATA_WIDTH-1:0]               step_i,
    input  logic [g_DATA_WIDTH-1:0]               low_i,
    input  logic [g_DATA_WIDTH-1:0]               high_i,
    input  logic [g_HOLD_WIDTH-1:0]               hold_i,
    input  logic [g_NB_CHANNELS-1:0]              inv_i,
    input  logic [g_NB_CHANNELS*g_DATA_WIDTH-1:0] adc_data_i,
    input  logic                                  adc_valid_i,
    output logic [g_NB_CHANNELS*g_DATA_WIDTH-1:0] adc_data_o,
    output logic                                  adc_valid_o,
    output logic                                  wrap_o,
    output logic                                  active_o
);

    localparam int c_W  = g_DATA_WIDTH;
    localparam int c_AW = g_DATA_WIDTH + 2;

    localparam logic [1:0] c_MODE_TRI   = 2'd0;
    localparam logic [1:0] c_MODE_SAW   = 2'd1;
    localparam logic [1:0] c_MODE_SQR   = 2'd2;
    localparam logic [1:0] c_MODE_CONST = 2'd3;

    localparam logic signed [c_W-1:0]  c_MIN = {1'b1, {(c_W-1){1'b0}}};
    localparam logic signed [c_W-1:0]  c_MAX = {1'b0, {(c_W-1){1'b1}}};
    localparam logic [g_HOLD_WIDTH-1:0] c_ONE = {{(g_HOLD_WIDTH-1){1'b0}}, 1'b1};

    logic                            en_q;
    logic                            active_q;
    logic                            frozen_q;
    logic [1:0]                      mode_q;
    logic [c_W-1:0]                  step_q;
    logic signed [c_W-1:0]           low_q;
    logic signed [c_W-1:0]           high_q;
    logic [g_HOLD_WIDTH-1:0]         hold_q;
    logic [g_NB_CHANNELS-1:0]        inv_q;

    logic signed [c_W-1:0]           value_q, value_d;
    logic                            dir_q, dir_d;
    logic [g_HOLD_WIDTH-1:0]         cnt_q, cnt_d;
    logic                            wrap_pend_q, wrap_pend_d;

    logic [g_NB_CHANNELS*c_W-1:0]    data_o_q;
    logic                            valid_o_q;
    logic                            wrap_o_q;

    logic                            w_rise;
    logic                            w_gen;
    logic                            w_adv;
    logic                            w_cfg_deg;
    logic signed [c_AW-1:0]          w_val_x, w_step_x, w_low_x, w_high_x, w_up, w_dn;
    logic signed [c_W-1:0]           w_neg;
    logic [g_NB_CHANNELS*c_W-1:0]    w_pat;

    assign w_rise    = en_i & ~en_q;
    // Gating on en_i too makes a sample coincident with the falling edge pass through.
    assign w_gen     = active_q & en_i;
    assign w_adv     = adc_valid_i & w_gen & ~frozen_q;
    assign w_cfg_deg = ($signed(low_i) >= $signed(high_i));

    assign w_val_x  = {{2{value_q[c_W-1]}}, value_q};
    assign w_step_x = {2'b00, step_q};
    assign w_low_x  = {{2{low_q[c_W-1]}}, low_q};
    assign w_high_x = {{2{high_q[c_W-1]}}, high_q};
    assign w_up     = w_val_x + w_step_x;
    assign w_dn     = w_val_x - w_step_x;

    assign w_neg = (value_q == c_MIN) ? c_MAX : -value_q;

    genvar k;
    generate
        for (k = 0; k < g_NB_CHANNELS; k++) begin : g_ch
            assign w_pat[k*c_W +: c_W] = inv_q[k] ? w_neg : value_q;
        end
    endgenerate

    always_comb begin
        value_d     = value_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        wrap_pend_d = wrap_pend_q;
        if (w_rise) begin
            dir_d       = 1'b0;
            cnt_d       = '0;
            wrap_pend_d = 1'b0;
            value_d     = (w_cfg_deg || mode_i != c_MODE_CONST) ? $signed(low_i) : $signed(high_i);
        end else if (w_adv) begin
            // wrap_pend marks the value now being loaded; it is reported when emitted.
            wrap_pend_d = 1'b0;
            case (mode_q)
                c_MODE_TRI: begin
                    if (!dir_q) begin
                        if (w_up >= w_high_x) begin
                            value_d     = high_q;
                            dir_d       = 1'b1;
                            wrap_pend_d = 1'b1;
                        end else begin
                            value_d = w_up[c_W-1:0];
                        end
                    end else begin
                        if (w_dn <= w_low_x) begin
                            value_d = low_q;
                            dir_d   = 1'b0;
                        end else begin
                            value_d = w_dn[c_W-1:0];
                        end
                    end
                end
                c_MODE_SAW: begin
                    if (w_up > w_high_x) begin
                        value_d     = low_q;
                        wrap_pend_d = 1'b1;
                    end else begin
                        value_d = w_up[c_W-1:0];
                    end
                end
                c_MODE_SQR: begin
                    if (cnt_q == hold_q) begin
                        cnt_d       = '0;
                        dir_d       = ~dir_q;
                        value_d     = dir_q ? low_q : high_q;
                        wrap_pend_d = ~dir_q;
                    end else begin
                        cnt_d = cnt_q + c_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            // Held high so a level-high en_i after reset needs a fresh toggle.
            en_q        <= 1'b1;
            active_q    <= 1'b0;
            frozen_q    <= 1'b0;
            mode_q      <= '0;
            step_q      <= '0;
            low_q       <= '0;
            high_q      <= '0;
            hold_q      <= '0;
            inv_q       <= '0;
            value_q     <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            wrap_pend_q <= 1'b0;
            data_o_q    <= '0;
            valid_o_q   <= 1'b0;
            wrap_o_q    <= 1'b0;
        end else begin
            en_q <= en_i;
            if (w_rise) begin
                active_q <= 1'b1;
                frozen_q <= w_cfg_deg | (step_i == '0);
                mode_q   <= mode_i;
                step_q   <= step_i;
                low_q    <= $signed(low_i);
                high_q   <= $signed(high_i);
                hold_q   <= hold_i;
                inv_q    <= inv_i;
            end else if (!en_i) begin
                active_q <= 1'b0;
            end
            value_q     <= value_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            wrap_pend_q <= wrap_pend_d;
            valid_o_q   <= adc_valid_i;
            wrap_o_q    <= adc_valid_i & w_gen & wrap_pend_q;
            if (adc_valid_i) begin
                data_o_q <= w_gen ? w_pat : adc_data_i;
            end
        end
    end

    assign adc_data_o  = data_o_q;
    assign adc_valid_o = valid_o_q;
    assign wrap_o      = wrap_o_q;
    assign active_o    = active_q;

endmodule
`default_nettype wire

// File: tb/tb_fmc_adc_pattern_gen.sv
`default_nettype none
// Directed testbench for fmc_adc_pattern_gen (4 channels x 16 bits).
module tb_fmc_adc_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] step = 16'd0;
    logic [15:0] low = 16'd0;
    logic [15:0] high = 16'd0;
    logic [15:0] hold = 16'd0;
    logic [3:0]  inv = 4'd0;
    logic [63:0] din = 64'd0;
    logic        vin = 1'b0;
    logic [63:0] dout;
    logic        vout;
    logic        wrap;
    logic        active;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fmc_adc_pattern_gen #(
        .g_NB_CHANNELS(4),
        .g_DATA_WIDTH (16),
        .g_HOLD_WIDTH (16)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst),
        .en_i       (en),
        .mode_i     (mode),
        .step_i     (step),
        .low_i      (low),
        .high_i     (high),
        .hold_i     (hold),
        .inv_i      (inv),
        .adc_data_i (din),
        .adc_valid_i(vin),
        .adc_data_o (dout),
        .adc_valid_o(vout),
        .wrap_o     (wrap),
        .active_o   (active)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rep4(input int v);
        logic [15:0] s;
        s = 16'(v);
        return {4{s}};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vecs++; if (dout !== 64'd0)   begin errs++; $display("FAIL reset_data got %h want 0", dout); end
        vecs++; if (vout !== 1'b0)    begin errs++; $display("FAIL reset_valid got %b want 0", vout); end
        vecs++; if (wrap !== 1'b0)    begin errs++; $display("FAIL reset_wrap got %b want 0", wrap); end
        vecs++; if (active !== 1'b0)  begin errs++; $display("FAIL reset_active got %b want 0", active); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        en = 1'b0; din = rep4(16'h1234); vin = 1'b1;
        tick();
        vin = 1'b0;
        vecs++; if ({dout, vout, active} !== {rep4(16'h1234), 1'b1, 1'b0})
            begin errs++; $display("FAIL pass_data got %h/%b/%b want %h/1/0", dout, vout, active, rep4(16'h1234)); end
        tick();
        vecs++; if ({dout, vout, wrap} !== {rep4(16'h1234), 1'b0, 1'b0})
            begin errs++; $display("FAIL pass_hold got %h/%b/%b want %h/0/0", dout, vout, wrap, rep4(16'h1234)); end
    endtask

    task automatic test_triangle();
        int exp_v;
        logic exp_w;
        mode = 2'd0; low = 16'(-400); high = 16'd400; step = 16'd8; inv = 4'd0;
        en = 1'b1;
        tick();
        vecs++; if (active !== 1'b1) begin errs++; $display("FAIL tri_active got %b want 1", active); end
        vin = 1'b1; din = rep4(16'h5555);
        for (int n = 1; n <= 210; n++) begin
            tick();
            if (n <= 101)      exp_v = -400 + 8 * (n - 1);
            else if (n <= 201) exp_v = 400 - 8 * (n - 101);
            else               exp_v = -400 + 8 * (n - 201);
            exp_w = (n == 101);
            vecs++; if ({dout, vout, wrap} !== {rep4(exp_v), 1'b1, exp_w})
                begin errs++; $display("FAIL tri_sample%0d got %h/%b/%b want %h/1/%b", n, dout, vout, wrap, rep4(exp_v), exp_w); end
        end
        vin = 1'b0;
        en = 1'b0;
        tick();
        vecs++; if ({vout, wrap, active} !== 3'b000) begin errs++; $display("FAIL tri_stop got %b%b%b want 000", vout, wrap, active); end
    endtask

    task automatic test_sawtooth();
        int exp_v[7] = '{0, 4, 8, 0, 4, 8, 0};
        logic exp_w[7] = '{0, 0, 0, 1, 0, 0, 1};
        mode = 2'd1; low = 16'd0; high = 16'd10; step = 16'd4; inv = 4'd0;
        en = 1'b1; vin = 1'b1; din = 64'h0123_4567_89AB_CDEF;
        tick();
        vecs++; if ({dout, active} !== {64'h0123_4567_89AB_CDEF, 1'b1})
            begin errs++; $display("FAIL saw_edge_pass got %h/%b want 0123456789abcdef/1", dout, active); end
        for (int n = 0; n < 7; n++) begin
            tick();
            vecs++; if ({dout, vout, wrap} !== {rep4(exp_v[n]), 1'b1, exp_w[n]})
                begin errs++; $display("FAIL saw_sample%0d got %h/%b/%b want %h/1/%b", n, dout, vout, wrap, rep4(exp_v[n]), exp_w[n]); end
            if (n == 2) begin
                vin = 1'b0;
                tick();
                vecs++; if ({dout, vout, wrap} !== {rep4(8), 1'b0, 1'b0})
                    begin errs++; $display("FAIL saw_gap got %h/%b/%b want %h/0/0", dout, vout, wrap, rep4(8)); end
                vin = 1'b1;
            end
        end
        vin = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_square_inv();
        logic [15:0] a, b;
        logic exp_w;
        mode = 2'd2; low = 16'(-100); high = 16'd100; hold = 16'd2; step = 16'd1; inv = 4'b0010;
        en = 1'b1;
        tick();
        vin = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            // Inputs changed mid-pattern must be ignored.
            if (n == 6) begin high = 16'd50; mode = 2'd0; inv = 4'b0000; end
            a = (((n - 1) / 3) % 2 == 1) ? 16'd100 : 16'(-100);
            b = 16'(-$signed(a));
            exp_w = ((n - 1) % 6 == 3);
            vecs++; if ({dout, vout, wrap} !== {a, a, b, a, 1'b1, exp_w})
                begin errs++; $display("FAIL sqr_sample%0d got %h/%b/%b want %h/1/%b", n, dout, vout, wrap, {a, a, b, a}, exp_w); end
        end
        vin = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_edge_cases();
        mode = 2'd3; low = 16'h8000; high = 16'h8000; step = 16'd3; inv = 4'b0001;
        en = 1'b1;
        tick();
        vin = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            vecs++; if ({dout, wrap} !== {16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 1'b0})
                begin errs++; $display("FAIL const_min_sample%0d got %h/%b want 8000800080007fff/0", n, dout, wrap); end
        end
        vin = 1'b0; en = 1'b0;
        tick();
        mode = 2'd0; low = 16'(-5); high = 16'd5; step = 16'd0; inv = 4'd0;
        en = 1'b1;
        tick();
        vin = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            vecs++; if ({dout, wrap} !== {rep4(-5), 1'b0})
                begin errs++; $display("FAIL step0_sample%0d got %h/%b want %h/0", n, dout, wrap, rep4(-5)); end
        end
        en = 1'b0; din = rep4(16'h0BAD);
        tick();
        vin = 1'b0;
        vecs++; if ({dout, vout, active} !== {rep4(16'h0BAD), 1'b1, 1'b0})
            begin errs++; $display("FAIL en_fall_pass got %h/%b/%b want %h/1/0", dout, vout, active, rep4(16'h0BAD)); end
    endtask

    task automatic test_reset_mid();
        mode = 2'd0; low = 16'd0; high = 16'd100; step = 16'd10; inv = 4'd0;
        en = 1'b1;
        tick();
        vin = 1'b1;
        for (int n = 1; n <= 4; n++) tick();
        vecs++; if (dout !== rep4(30)) begin errs++; $display("FAIL rmid_pre got %h want %h", dout, rep4(30)); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++; if ({dout, vout, wrap, active} !== {64'd0, 3'b000})
            begin errs++; $display("FAIL rmid_reset got %h/%b/%b/%b want 0/0/0/0", dout, vout, wrap, active); end
        din = rep4(16'h7777);
        tick();
        vecs++; if ({dout, vout, active} !== {rep4(16'h7777), 1'b1, 1'b0})
            begin errs++; $display("FAIL rmid_no_edge got %h/%b/%b want %h/1/0", dout, vout, active, rep4(16'h7777)); end
        vin = 1'b0; en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        vin = 1'b1;
        tick();
        vecs++; if ({dout, active} !== {rep4(0), 1'b1})
            begin errs++; $display("FAIL rmid_restart0 got %h/%b want %h/1", dout, active, rep4(0)); end
        tick();
        vecs++; if (dout !== rep4(10)) begin errs++; $display("FAIL rmid_restart1 got %h want %h", dout, rep4(10)); end
        vin = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_triangle();
        test_sawtooth();
        test_square_inv();
        test_edge_cases();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
